// File: rtl/lane_spawner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lane_spawner_pkg
// Brief   : Shared game types: lane FSM state and common offset width.
// Revision: 1.0
// ============================================================================
package lane_spawner_pkg;

    localparam int c_offset_width = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } lane_state_t;

endpackage : lane_spawner_pkg
`default_nettype wire

// File: rtl/lane_spawner_if.sv
`default_nettype none
// ============================================================================
// Module  : lane_spawner_if
// Brief   : Frame strobe / launch request in, sprite offsets and status out.
// Revision: 1.0
// ============================================================================
interface lane_spawner_if #(
    parameter int HWIDTH = 12,
    parameter int VWIDTH = 12
);
    logic              tick;
    logic              en;
    logic [HWIDTH-1:0] hoffset;
    logic [VWIDTH-1:0] voffset;
    logic              active;

    modport master (
        output tick,
        output en,
        input  hoffset,
        input  voffset,
        input  active
    );

    modport slave (
        input  tick,
        input  en,
        output hoffset,
        output voffset,
        output active
    );
endinterface : lane_spawner_if
`default_nettype wire

// File: rtl/lane_spawner_axis_lerp.sv
`default_nettype none
// ============================================================================
// Module  : axis_lerp
// Brief   : Combinational per-axis interpolator, SRC + ((DST-SRC)*k) >>> log2(STEP).
// Revision: 1.0
// ============================================================================
module axis_lerp #(
    parameter int WIDTH = 12,
    parameter int SRC   = 0,
    parameter int DST   = 0,
    parameter int STEP  = 32
) (
    input  wire logic [$clog2(STEP):0] k,
    output logic      [WIDTH-1:0]      pos
);
    localparam int c_log   = $clog2(STEP);
    localparam int c_pw    = WIDTH + 2 + c_log;
    localparam int c_diff  = DST - SRC;
    localparam logic [WIDTH-1:0] c_src = WIDTH'(SRC);
    // Difference kept in WIDTH+1 bits so a full-range swing never overflows
    localparam logic signed [WIDTH:0] c_diff_w = (WIDTH+1)'(c_diff);

    logic signed [c_pw-1:0] w_diff_ext;
    logic signed [c_pw-1:0] w_k_ext;
    logic signed [c_pw-1:0] w_prod;
    logic        [WIDTH-1:0] w_step_off;

    assign w_diff_ext = {{(c_pw-WIDTH-1){c_diff_w[WIDTH]}}, c_diff_w};
    assign w_k_ext    = {{(c_pw-c_log-1){1'b0}}, k};
    assign w_prod     = w_diff_ext * w_k_ext;
    // Arithmetic shift floors toward -inf; the sum wraps modulo 2^WIDTH
    assign w_step_off = WIDTH'(w_prod >>> c_log);
    assign pos        = c_src + w_step_off;

endmodule : axis_lerp
`default_nettype wire

// File: rtl/lane_spawner.sv
`default_nettype none
// ============================================================================
// Module  : lane_spawner
// Brief   : Per-lane object mover; launches on tick&en, walks SRC->DST in STEP ticks.
// Revision: 1.0
// ============================================================================
module lane_spawner
    import lane_spawner_pkg::*;
#(
    parameter int HWIDTH = c_offset_width,
    parameter int VWIDTH = c_offset_width,
    parameter int HSRC   = 0,
    parameter int VSRC   = 0,
    parameter int HDST   = 0,
    parameter int VDST   = 0,
    parameter int STEP   = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    lane_spawner_if.slave      bus
);
    localparam int c_log = $clog2(STEP);
    localparam logic [c_log:0]    c_step = (c_log+1)'(STEP);
    localparam logic [HWIDTH-1:0] c_hsrc = HWIDTH'(HSRC);
    localparam logic [VWIDTH-1:0] c_vsrc = VWIDTH'(VSRC);

    lane_state_t       r_state;
    logic [c_log:0]    r_k;
    logic [HWIDTH-1:0] r_hoffset;
    logic [VWIDTH-1:0] r_voffset;
    logic              r_active;

    logic [c_log:0]    w_k_next;
    logic [HWIDTH-1:0] w_hpos;
    logic [VWIDTH-1:0] w_vpos;

    // Interpolators look one step ahead so the outputs can stay registered
    assign w_k_next = r_k + 1'b1;

    axis_lerp #(.WIDTH(HWIDTH), .SRC(HSRC), .DST(HDST), .STEP(STEP)) u_hlerp (
        .k   (w_k_next),
        .pos (w_hpos)
    );

    axis_lerp #(.WIDTH(VWIDTH), .SRC(VSRC), .DST(VDST), .STEP(STEP)) u_vlerp (
        .k   (w_k_next),
        .pos (w_vpos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_hoffset <= c_hsrc;
            r_voffset <= c_vsrc;
            r_active  <= 1'b0;
        end else if (bus.tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        r_state  <= ST_MOVE;
                        r_k      <= '0;
                        r_active <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (r_k == c_step) begin
                        r_state   <= ST_IDLE;
                        r_k       <= '0;
                        r_hoffset <= c_hsrc;
                        r_voffset <= c_vsrc;
                        r_active  <= 1'b0;
                    end else begin
                        r_k       <= w_k_next;
                        r_hoffset <= w_hpos;
                        r_voffset <= w_vpos;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_k      <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hoffset = r_hoffset;
    assign bus.voffset = r_voffset;
    assign bus.active  = r_active;

endmodule : lane_spawner
`default_nettype wire

// File: tb/tb_lane_spawner.sv
`default_nettype none
// ============================================================================
// Module  : tb_lane_spawner
// Brief   : Directed self-checking bench for lane_spawner with hand-computed vectors.
// Revision: 1.0
// ============================================================================
module tb_lane_spawner;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lane_spawner_if #(.HWIDTH(12), .VWIDTH(12)) bus ();

    lane_spawner #(
        .HWIDTH (12),
        .VWIDTH (12),
        .HSRC   (-80),
        .VSRC   (-140),
        .HDST   (-120),
        .VDST   (220),
        .STEP   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check3(input string tag, input int eh, input int ev, input logic ea);
        logic [11:0] xh;
        logic [11:0] xv;
        xh = 12'(eh);
        xv = 12'(ev);
        total++;
        assert (bus.hoffset === xh) else begin
            bad++;
            $error("FAIL %s hoffset got %0d expected %0d", tag, $signed(bus.hoffset), $signed(xh));
        end
        total++;
        assert (bus.voffset === xv) else begin
            bad++;
            $error("FAIL %s voffset got %0d expected %0d", tag, $signed(bus.voffset), $signed(xv));
        end
        total++;
        assert (bus.active === ea) else begin
            bad++;
            $error("FAIL %s active got %b expected %b", tag, bus.active, ea);
        end
    endtask

    // One-cycle tick strobe; outputs sampled on the following falling edge
    task automatic do_tick(input logic en_val);
        bus.en   = en_val;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic en_val);
        for (int i = 0; i < n; i++) do_tick(en_val);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        bus.tick = 1'b0;
        bus.en   = 1'b0;

        // Asynchronous reset, checked before any rising edge
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 check3("reset_async", -80, -140, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check3("after_reset", -80, -140, 1'b0);

        // Launch then first step
        do_tick(1'b1);
        check3("launch", -80, -140, 1'b1);
        repeat (3) @(negedge clk);
        check3("hold_between_ticks", -80, -140, 1'b1);
        do_tick(1'b0);
        check3("k1", -82, -129, 1'b1);
        ticks(15, 1'b0);
        check3("k16", -100, 40, 1'b1);
        ticks(15, 1'b0);
        check3("k31", -119, 208, 1'b1);
        do_tick(1'b0);
        check3("k32", -120, 220, 1'b1);
        do_tick(1'b1);
        check3("return_idle", -80, -140, 1'b0);

        // Continuous en: one idle tick between trajectories
        ticks(1, 1'b1);
        check3("relaunch_a", -80, -140, 1'b1);
        ticks(32, 1'b1);
        check3("cont_k32", -120, 220, 1'b1);
        ticks(1, 1'b1);
        check3("cont_idle", -80, -140, 1'b0);
        ticks(1, 1'b1);
        check3("cont_relaunch", -80, -140, 1'b1);
        ticks(1, 1'b1);
        check3("cont_k1", -82, -129, 1'b1);
        ticks(9, 1'b1);
        check3("cont_k10", -93, -28, 1'b1);

        // Mid-flight reset
        bus.en = 1'b0;
        #1 rst_n = 1'b0;
        #2 check3("mid_reset", -80, -140, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_tick(1'b0);
        check3("post_reset_idle", -80, -140, 1'b0);

        // en high without tick
        bus.en = 1'b1;
        repeat (100) @(negedge clk);
        check3("en_no_tick", -80, -140, 1'b0);
        do_tick(1'b1);
        check3("launch_after_wait", -80, -140, 1'b1);
        do_tick(1'b0);
        check3("k1_after_wait", -82, -129, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lane_spawner
`default_nettype wire

// File: doc/lane_spawner.md
# lane_spawner

Per-lane object mover for the game-screen sprites: on a frame tick with `en` high, it launches one object along a straight line from a source offset to a destination offset in `STEP` equal frame steps, then parks it. The offsets it emits drive the horizontal and vertical offset inputs of a sprite layer, one instance per lane. The launch request normally comes from pseudo-random bits.

## Interface
Parameters:
- `HWIDTH`, 12: horizontal offset width, two's complement.
- `VWIDTH`, 12: vertical offset width, two's complement.
- `HSRC`, 0: horizontal start offset, signed.
- `VSRC`, 0: vertical start offset, signed; also the park position.
- `HDST`, 0: horizontal end offset, signed.
- `VDST`, 0: vertical end offset, signed.
- `STEP`, 32: frame steps per trajectory; power of two, ≥2.

Ports:
- `clk`  in  1: single system clock.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `tick`  in  1: one-cycle frame strobe; all state advances only on cycles with `tick`=1.
- `en`  in  1: launch request, sampled only when `tick`=1 in IDLE.
- `hoffset`  out  HWIDTH: current horizontal offset, registered.
- `voffset`  out  VWIDTH: current vertical offset, registered.
- `active`  out  1: high while the object is in flight (MOVE).

## Operation
- States are IDLE and MOVE. A step counter `k` runs from 0 to STEP.
- Reset puts the block in IDLE with k=0, `hoffset`=HSRC, `voffset`=VSRC and `active`=0.
- In IDLE with `tick`=1 and `en`=1, the block goes to MOVE with k=0. The outputs stay at SRC and `active` goes to 1.
- In IDLE with `tick`=0 or `en`=0, nothing changes.
- In MOVE with `tick`=1 and k<STEP, k increments and the outputs take the position for the new k.
- In MOVE with `tick`=1 and k=STEP, the block returns to IDLE, sets k=0, puts the outputs back to SRC and drops `active`.
- `en` is ignored during MOVE and on the tick that returns the block to IDLE. After each trajectory the block stays in IDLE for at least one full tick.
- Position for step k, computed per axis:
  - pos = SRC + ((DST − SRC) · k) >>> log2(STEP).
  - The shift is arithmetic, so the result is floored toward −∞.
  - At k=STEP the result is exactly DST.
- Width rules:
  - Compute the difference in WIDTH+1 signed bits.
  - Compute the product in WIDTH+2+log2(STEP) signed bits.
  - Truncate the final sum to WIDTH bits, wrapping modulo 2^WIDTH.
- When DST = SRC the axis stays constant at SRC.

## Timing
- All outputs are registered and update on the rising `clk` edge of a `tick` cycle.
- No combinational path from any input to any output.
- Launch latency: the tick that samples `en` makes `active` high. The first moved position (k=1) appears on the next tick.
- Dwell: the object is in MOVE for STEP+1 ticks. Between ticks the outputs hold.
- Asserting `rst_n` low forces the reset values immediately, even in the middle of a trajectory.
- Release of `rst_n` must be synchronised to `clk` outside this block.

## Structure
- Shared game package holds the lane-state enum (IDLE, MOVE) and the common offset width constant (12).
- A natural sub-module is `axis_lerp` (parameters WIDTH, SRC, DST, STEP). It is a combinational per-axis interpolator and is instantiated once for H and once for V.
- The pseudo-random source feeding `en` lives outside this block.

## Test plan
Defaults for all scenarios: HSRC=−80, VSRC=−140, HDST=−120, VDST=220, STEP=32.
- Reset with `rst_n`=0 → `hoffset`=0xFB0 (−80), `voffset`=0xF74 (−140), `active`=0. The reset takes effect with no clock edge.
- One tick with `en`=1, then one tick with `en`=0 →
  - first tick: `active`=1, offsets still (−80, −140);
  - second tick: (−82, −129), since floor(−40/32)=−2 and floor(360/32)=11.
- Continue ticking →
  - k=16 gives (−100, 40);
  - k=32 gives (−120, 220);
  - the next tick returns (−80, −140) with `active`=0.
- Hold `en`=1 for every tick → the outputs return to SRC with `active`=0 for exactly one tick, then relaunch. Period is STEP+2 ticks.
- Pulse `rst_n` low at k=10 → immediate return to (−80, −140) with `active`=0. A following `tick` with `en`=0 keeps the block idle.
- `en`=1 with `tick`=0 for 100 cycles → no state or output change.
